// File: rtl/present_enc_arbiter_if.sv
// Request, response and core-side bundle shared by the PRESENT encryption arbiter and its environment.
interface present_enc_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*64-1:0]  req_pt;
    logic [NREQ*128-1:0] req_key;
    logic                resp_valid;
    logic                resp_ready;
    logic [63:0]         resp_ct;
    logic [IDW-1:0]      resp_id;
    logic                resp_err;
    logic                core_load;
    logic [63:0]         core_in_data;
    logic [127:0]        core_key;
    logic [63:0]         core_out_data;
    logic                core_done;

    // Arbiter side of the bundle.
    modport slave (
        input  req_valid, req_pt, req_key, resp_ready, core_out_data, core_done,
        output req_ready, resp_valid, resp_ct, resp_id, resp_err,
               core_load, core_in_data, core_key
    );

    // Requesters, response consumer and encryption core side of the bundle.
    modport master (
        output req_valid, req_pt, req_key, resp_ready, core_out_data, core_done,
        input  req_ready, resp_valid, resp_ct, resp_id, resp_err,
               core_load, core_in_data, core_key
    );
endinterface

// File: rtl/present_enc_arbiter.sv
// Round-robin arbiter sharing one PRESENT-128 encryption core between NREQ requesters.
// Optional BUSY watchdog enabled by defining PRESENT_ARB_TIMEOUT_EN.
module present_enc_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
`ifdef PRESENT_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 40
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    present_enc_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BUSY = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    state_e         state_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] owner_q;
    logic           core_load_q;
    logic [63:0]    core_in_data_q;
    logic [127:0]   core_key_q;
    logic           resp_valid_q;
    logic [63:0]    resp_ct_q;
    logic [IDW-1:0] resp_id_q;
`ifdef PRESENT_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic           resp_err_q;
    logic [7:0]     tmo_cnt_q;
`endif

    logic           grant_found_s;
    logic [IDW-1:0] grant_idx_s;
    logic [IDW:0]   cand_sum_s;
    logic [IDW-1:0] cand_s;
    logic [IDW-1:0] rr_next_s;
    logic [NREQ-1:0] grant_onehot_s;
    logic [63:0]    pt_sel_s;
    logic [127:0]   key_sel_s;

    // Round-robin search: walking offsets downward lets the smallest offset from rr_ptr win.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_sum_s    = '0;
        cand_s        = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand_sum_s = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            cand_s     = (cand_sum_s >= (IDW+1)'(NREQ)) ? IDW'(cand_sum_s - (IDW+1)'(NREQ))
                                                        : IDW'(cand_sum_s);
            if (bus.req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // Select the granted requester's plaintext and key.
    always_comb begin
        pt_sel_s  = '0;
        key_sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx_s == IDW'(i)) begin
                pt_sel_s  = bus.req_pt[64*i +: 64];
                key_sel_s = bus.req_key[128*i +: 128];
            end else begin
                pt_sel_s  = pt_sel_s;
                key_sel_s = key_sel_s;
            end
        end
    end

    // Accept strobe: only in IDLE and never while reset is asserted.
    always_comb begin
        grant_onehot_s = '0;
        if ((state_q == ST_IDLE) && grant_found_s && rst_n) begin
            grant_onehot_s[grant_idx_s] = 1'b1;
        end else begin
            grant_onehot_s = '0;
        end
    end

    assign rr_next_s = (grant_idx_s == IDW'(NREQ - 1)) ? '0 : grant_idx_s + IDW'(1);

    // Job sequencer: IDLE -> LOAD -> BUSY -> RESP with all core/response outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            core_load_q    <= 1'b0;
            core_in_data_q <= 64'd0;
            core_key_q     <= 128'd0;
            resp_valid_q   <= 1'b0;
            resp_ct_q      <= 64'd0;
            resp_id_q      <= '0;
`ifdef PRESENT_ARB_TIMEOUT_EN
            resp_err_q     <= 1'b0;
            tmo_cnt_q      <= 8'd0;
`endif
        end else begin
            core_load_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        owner_q        <= grant_idx_s;
                        rr_ptr_q       <= rr_next_s;
                        core_in_data_q <= pt_sel_s;
                        core_key_q     <= key_sel_s;
                        core_load_q    <= 1'b1;
                        state_q        <= ST_LOAD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
`ifdef PRESENT_ARB_TIMEOUT_EN
                    tmo_cnt_q <= 8'd0;
`endif
                    state_q <= ST_BUSY;
                end
                ST_BUSY: begin
                    // core_done is trusted only here; elsewhere it may be stale.
                    if (bus.core_done) begin
                        resp_ct_q    <= bus.core_out_data;
                        resp_id_q    <= owner_q;
                        resp_valid_q <= 1'b1;
`ifdef PRESENT_ARB_TIMEOUT_EN
                        resp_err_q   <= 1'b0;
`endif
                        state_q      <= ST_RESP;
`ifdef PRESENT_ARB_TIMEOUT_EN
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        resp_ct_q    <= 64'd0;
                        resp_id_q    <= owner_q;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                        state_q   <= ST_BUSY;
                    end
`else
                    end else begin
                        state_q <= ST_BUSY;
                    end
`endif
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = grant_onehot_s;
    assign bus.core_load    = core_load_q;
    assign bus.core_in_data = core_in_data_q;
    assign bus.core_key     = core_key_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_ct      = resp_ct_q;
    assign bus.resp_id      = resp_id_q;
`ifdef PRESENT_ARB_TIMEOUT_EN
    assign bus.resp_err     = resp_err_q;
`else
    assign bus.resp_err     = 1'b0;
`endif

endmodule
